// File: rtl/conv_stream_feeder.sv
// Feeds conv_top: weight words, GAP idle cycles, then pixel words (zero border with FEED_ZERO_PAD_EN).
// Latency: first po_weight_valid 3 edges after start is sampled; done one cycle after last pixel word.
// Backpressure: none; streams run at one word per cycle once started, start while busy is ignored.
module conv_stream_feeder #(
    parameter int KERNEL  = 3,
    parameter int WADDR_W = 4,
    parameter int DADDR_W = 18,
    parameter int GAP     = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start,
    input  logic [8:0]         image_size,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [WADDR_W-1:0] weight_addr,
    input  logic [15:0]        weight_rdata,
    output logic [DADDR_W-1:0] data_addr,
    input  logic [15:0]        data_rdata,
    output logic               po_weight_valid,
    output logic [15:0]        po_weight,
    output logic               po_data_valid,
    output logic [15:0]        po_data
);

    localparam int CW = DADDR_W + 1;
    localparam logic [CW-1:0] KK_LAST  = CW'(KERNEL * KERNEL - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [CW-1:0] FL_LAST  = CW'(2);
    localparam logic [8:0]    KERNEL_N = 9'(KERNEL);

    typedef enum logic [2:0] {IDLE, WREAD, GAPW, DREAD, FLUSH} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] last_q;
    logic [CW-1:0] last_nx;
    logic [CW-1:0] words_nx;
    logic [9:0]    side_nx;
    logic          accept, reject, w_iss, d_iss, cnt_clr, fin;
    logic          w_v1, w_v2, d_v1, d_v2;

`ifdef FEED_ZERO_PAD_EN
    assign side_nx = {1'b0, image_size} + 10'd2;
`else
    assign side_nx = {1'b0, image_size};
`endif
    assign words_nx = {{(CW-10){1'b0}}, side_nx} * {{(CW-10){1'b0}}, side_nx};
    assign last_nx  = words_nx - CW'(1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        reject   = 1'b0;
        w_iss    = 1'b0;
        d_iss    = 1'b0;
        cnt_clr  = 1'b0;
        fin      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (image_size >= KERNEL_N) begin
                        accept   = 1'b1;
                        cnt_clr  = 1'b1;
                        state_nx = WREAD;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            WREAD: begin
                w_iss = 1'b1;
                if (cnt == KK_LAST) begin
                    cnt_clr  = 1'b1;
                    state_nx = GAPW;
                end
            end
            GAPW: begin
                if (cnt == GAP_LAST) begin
                    cnt_clr  = 1'b1;
                    state_nx = DREAD;
                end
            end
            DREAD: begin
                d_iss = 1'b1;
                if (cnt == last_q) begin
                    cnt_clr  = 1'b1;
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                // Two pipeline stages plus the output register still hold the tail.
                if (cnt == FL_LAST) begin
                    cnt_clr  = 1'b1;
                    fin      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt    <= '0;
            last_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            cnt  <= (cnt_clr || state == IDLE) ? '0 : cnt + CW'(1);
            done <= fin;
            err  <= reject;
            if (accept) begin
                last_q <= last_nx;
                busy   <= 1'b1;
            end else if (fin) begin
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            weight_addr     <= '0;
            w_v1            <= 1'b0;
            w_v2            <= 1'b0;
            po_weight_valid <= 1'b0;
            po_weight       <= '0;
        end else begin
            weight_addr     <= w_iss ? cnt[WADDR_W-1:0] : '0;
            w_v1            <= w_iss;
            w_v2            <= w_v1;
            po_weight_valid <= w_v2;
            if (w_v2) po_weight <= weight_rdata;
        end
    end

`ifdef FEED_ZERO_PAD_EN
    logic [9:0]         row, col, edge_q;
    logic [DADDR_W-1:0] pix;
    logic               border, rd, z1, z2;

    assign border = (row == 10'd0) || (row == edge_q) || (col == 10'd0) || (col == edge_q);
    assign rd     = d_iss && !border;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            row           <= '0;
            col           <= '0;
            edge_q        <= '0;
            pix           <= '0;
            z1            <= 1'b0;
            z2            <= 1'b0;
            data_addr     <= '0;
            d_v1          <= 1'b0;
            d_v2          <= 1'b0;
            po_data_valid <= 1'b0;
            po_data       <= '0;
        end else begin
            if (accept) begin
                row    <= '0;
                col    <= '0;
                pix    <= '0;
                edge_q <= side_nx - 10'd1;
            end else if (d_iss) begin
                if (col == edge_q) begin
                    col <= '0;
                    row <= row + 10'd1;
                end else begin
                    col <= col + 10'd1;
                end
                if (rd) pix <= pix + DADDR_W'(1);
            end
            data_addr     <= rd ? pix : '0;
            // Border words skip the memory and are forced to zero at the output stage.
            z1            <= d_iss && border;
            z2            <= z1;
            d_v1          <= d_iss;
            d_v2          <= d_v1;
            po_data_valid <= d_v2;
            if (d_v2) po_data <= z2 ? 16'd0 : data_rdata;
        end
    end
`else
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_addr     <= '0;
            d_v1          <= 1'b0;
            d_v2          <= 1'b0;
            po_data_valid <= 1'b0;
            po_data       <= '0;
        end else begin
            data_addr     <= d_iss ? cnt[DADDR_W-1:0] : '0;
            d_v1          <= d_iss;
            d_v2          <= d_v1;
            po_data_valid <= d_v2;
            if (d_v2) po_data <= data_rdata;
        end
    end
`endif

endmodule

// File: doc/conv_stream_feeder.md
Name: conv_stream_feeder

Overview:
- Source end of the conv_top input stream.
- On a start pulse it reads the kernel weights and then the image pixels from two synchronous-read ROM/RAM ports, and drives them in order as the weight stream (po_weight_valid/po_weight) followed by the pixel stream (po_data_valid/po_data). This is the same valid+16-bit protocol that conv_top consumes on pi_weight_*/pi_data_*.
- Sits between the frame/weight buffers and conv_top. It replaces the hand-timed valid windows used by the benches.

Parameters:
KERNEL, 3, kernel edge length; weight phase length is KERNEL*KERNEL words
WADDR_W, 4, weight address width; must satisfy 2^WADDR_W >= KERNEL*KERNEL
DADDR_W, 18, pixel address width; covers 511*511 pixels
GAP, 4, idle cycles (both valids low) between last weight word and first pixel word; GAP >= 1

Ports:
sys_clk  in  1  system clock, rising edge
sys_rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle launch request
image_size  in  9  image edge length N; sampled only when start is accepted
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last pixel word
err  out  1  one-cycle pulse when start is rejected for bad size
weight_addr  out  WADDR_W  weight memory read address
weight_rdata  in  16  weight word; valid one cycle after weight_addr
data_addr  out  DADDR_W  pixel memory read address
data_rdata  in  16  pixel word; valid one cycle after data_addr
po_weight_valid  out  1  weight word valid
po_weight  out  16  weight word
po_data_valid  out  1  pixel word valid
po_data  out  16  pixel word

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset asserted mid-frame aborts immediately. No done pulse is produced. Next frame needs a new start.
- FSM states: IDLE, WREAD, GAPW, DREAD, FLUSH.
- IDLE: start=1 with image_size >= KERNEL
  - latch N, go to WREAD, busy=1 next cycle.
- IDLE: start=1 with image_size < KERNEL
  - err=1 for one cycle; stay IDLE; no memory reads.
- start while busy: ignored, no err.
- WREAD: issues weight_addr = 0..KERNEL*KERNEL-1, one per cycle, then goes to GAPW.
- Output register: a read issued in cycle t has its rdata registered in cycle t+1. The registered word is presented on po_* with valid in cycle t+2, as a registered output.
- Weight timing:
  - First po_weight_valid is high 3 rising edges after the edge that sampled start.
  - po_weight_valid is high for exactly KERNEL*KERNEL consecutive cycles.
  - po_weight in the k-th valid cycle equals weight memory word k.
- GAPW: counts so that exactly GAP cycles have both valids low between the last weight word and the first pixel word. Then goes to DREAD.
- DREAD: issues data_addr = 0..N*N-1 in raster order, one per cycle.
  - po_data_valid is high for exactly N*N consecutive cycles.
  - po_data in the k-th valid cycle equals pixel word k.
- FLUSH: waits for the read pipeline to drain.
  - done=1 in the cycle after the last po_data_valid.
  - busy falls in that same cycle; return to IDLE.
  - A start in the done cycle is accepted.
- Valid exclusivity: po_weight_valid and po_data_valid are never high together.
- Data outputs when not valid: po_weight and po_data hold their last value.
- Address outputs when idle: return to 0.
- Counter widths: pixel counter is 18 bits; N=511 gives 261121 words, with no wrap.
- Words per frame: KERNEL*KERNEL + N*N for every accepted start.

Optional Feature:
- Macro: FEED_ZERO_PAD_EN.
- Defined: the data phase emits (N+2)*(N+2) words in raster order, adding a one-pixel zero border.
  - Border positions output 0 and do not issue a memory read.
  - Interior positions read pixels 0..N*N-1 in order.
  - po_data_valid stays contiguous for the whole (N+2)^2 words.
  - A 19-bit output counter is used; the pixel address stays DADDR_W bits.
- Undefined: no padding logic; the data phase is N*N words as above.

Test Plan:
- Reset then start with N=5, KERNEL=3, weight mem = 1..9, pixel mem = 100+i -> po_weight 1..9 on 9 consecutive cycles, first valid 3 edges after start; 4 idle cycles; po_data 100..124 on 25 cycles; done one cycle after word 124; busy low.
- start with image_size=2 -> err pulse 1 cycle, busy=0, no address change, no valids.
- Second start during data phase of an N=5 frame -> ignored; exactly 9+25 valid words total and one done pulse.
- sys_rst_n low at the 10th pixel word of N=8 -> all outputs 0 next instant, no done; new start gives a full 9+64 frame from address 0.
- start asserted in the done cycle of a first N=3 frame -> second frame accepted; 9+9 words each, with GAP=4 idle cycles between the phases of each frame.
- FEED_ZERO_PAD_EN with N=3, pixels 1..9 -> 25 data words: row0 all 0; rows 1-3 are 0,1,2,3,0 / 0,4,5,6,0 / 0,7,8,9,0; row4 all 0; exactly 9 data reads.
